song_reader: RTL and testbench

Note sequencer between the play controller and `note_player`, consuming `play`, `reset_play` and `song` and producing `song_done`. Walks the selected song's entries in `song_rom` and hands each note/duration pair to `note_player` with a one-cycle `new_note` strobe. Waits for `note_done` before fetching the next entry, and pulses `song_done` at end of song. Pause/resume is at note granularity: the current note always completes and the next fetch is held.

---
 rtl/music_pkg.sv | 26 ++
 rtl/song_reader_if.sv | 34 +++
 rtl/song_rom.sv | 63 ++++++
 rtl/song_reader.sv | 106 ++++++++++
 tb/tb_song_reader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// music_pkg
// Shared definitions for the song sequencer slice: field widths for note,
// duration, per-song index and song select, the end-of-song duration
// marker, and the sequencer state encoding.
package music_pkg;

  localparam int NOTE_BITS     = 6;
  localparam int DUR_BITS      = 6;
  localparam int ADDR_BITS     = 5;
  localparam int SONG_BITS     = 2;
  localparam int ROM_ADDR_BITS = SONG_BITS + ADDR_BITS;
  localparam int ROM_DATA_BITS = NOTE_BITS + DUR_BITS;

  // A duration of zero terminates a song early.
  localparam logic [DUR_BITS-1:0] END_MARKER = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WAIT,
    ADVANCE,
    DONE
  } state_t;

endpackage

// File: rtl/song_reader_if.sv
// song_reader_if
// Handshake bundle between the play controller / note_player side and the
// song_reader sequencer.
//   play        controller -> reader  level, allowed to fetch/issue notes
//   reset_play  controller -> reader  one-cycle restart pulse
//   song        controller -> reader  song select
//   note_done   player     -> reader  one-cycle "note finished" pulse
//   new_note    reader -> player      one-cycle strobe, note/duration valid
//   note        reader -> player      registered note code
//   duration    reader -> player      registered duration
//   song_done   reader -> controller  one-cycle end-of-song pulse
// master = controller/player side, slave = song_reader.
interface song_reader_if;

  logic                               play;
  logic                               reset_play;
  logic [music_pkg::SONG_BITS-1:0]    song;
  logic                               note_done;
  logic                               new_note;
  logic [music_pkg::NOTE_BITS-1:0]    note;
  logic [music_pkg::DUR_BITS-1:0]     duration;
  logic                               song_done;

  modport master (
    output play, reset_play, song, note_done,
    input  new_note, note, duration, song_done
  );

  modport slave (
    input  play, reset_play, song, note_done,
    output new_note, note, duration, song_done
  );

endinterface

// File: rtl/song_rom.sv
// song_rom
// 128 x 12 song table with a registered output (one-cycle read latency).
// Address is {song, index}, data is {note, duration}.
//   clk   in   system clock
//   addr  in   {song, index}
//   data  out  {note, duration}, valid the cycle after addr is presented
// Song contents:
//   song 0: 32 entries, note = i+1, duration = i+1 (no end marker)
//   song 1: 9 entries, note = i+20, duration 3; end marker at index 9
//   song 2: entry 0 = {17, 8}; others note = i+32, duration = i+1
//   song 3: 16 rests of duration 4; end marker at index 16
module song_rom
  import music_pkg::*;
(
  input  logic                     clk,
  input  logic [ROM_ADDR_BITS-1:0] addr,
  output logic [ROM_DATA_BITS-1:0] data
);

  function automatic logic [ROM_DATA_BITS-1:0] entry(
    input logic [SONG_BITS-1:0] s,
    input logic [ADDR_BITS-1:0] i
  );
    logic [NOTE_BITS-1:0] n;
    logic [DUR_BITS-1:0]  d;
    n = '0;
    d = END_MARKER;
    case (s)
      2'd0: begin
        n = NOTE_BITS'(i) + NOTE_BITS'(1);
        d = DUR_BITS'(i) + DUR_BITS'(1);
      end
      2'd1: begin
        if (i < ADDR_BITS'(9)) begin
          n = NOTE_BITS'(i) + NOTE_BITS'(20);
          d = DUR_BITS'(3);
        end
      end
      2'd2: begin
        if (i == '0) begin
          n = NOTE_BITS'(17);
          d = DUR_BITS'(8);
        end else begin
          n = NOTE_BITS'(i) + NOTE_BITS'(32);
          d = DUR_BITS'(i) + DUR_BITS'(1);
        end
      end
      default: begin
        if (i < ADDR_BITS'(16)) begin
          n = '0;
          d = DUR_BITS'(4);
        end
      end
    endcase
    return {n, d};
  endfunction

  // Plain ROM: no reset needed, the sequencer only trusts data in LATCH.
  always_ff @(posedge clk) begin
    data <= entry(addr[ROM_ADDR_BITS-1:ADDR_BITS], addr[ADDR_BITS-1:0]);
  end

endmodule

// File: rtl/song_reader.sv
// song_reader
// Note sequencer: walks the selected song in song_rom and hands each
// note/duration pair to note_player with a one-cycle new_note strobe, waits
// for note_done before the next fetch, and pulses song_done at end of song.
// Pausing (play low) takes effect between notes only.
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   bus    slave side of song_reader_if (play, reset_play, song, note_done
//          in; new_note, note, duration, song_done out)
module song_reader
  import music_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  song_reader_if.slave bus
);

  state_t                   state;
  logic [ADDR_BITS-1:0]     index;
  logic [ROM_ADDR_BITS-1:0] rom_addr;
  logic [ROM_DATA_BITS-1:0] rom_data;
  logic [NOTE_BITS-1:0]     rom_note;
  logic [DUR_BITS-1:0]      rom_dur;
  logic                     new_note_q;
  logic [NOTE_BITS-1:0]     note_q;
  logic [DUR_BITS-1:0]      dur_q;
  logic                     song_done_q;

  // Song select is sampled live so a song change lands on the next fetch.
  assign rom_addr = {bus.song, index};
  assign rom_note = rom_data[ROM_DATA_BITS-1:DUR_BITS];
  assign rom_dur  = rom_data[DUR_BITS-1:0];

  song_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Single FSM register block. Strobes default low every cycle so each is
  // exactly one cycle wide; reset_play outranks every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      index       <= '0;
      new_note_q  <= 1'b0;
      note_q      <= '0;
      dur_q       <= '0;
      song_done_q <= 1'b0;
    end else begin
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      if (bus.reset_play) begin
        state  <= IDLE;
        index  <= '0;
        note_q <= '0;
        dur_q  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.play) state <= FETCH;
          end
          FETCH: begin
            state <= LATCH;
          end
          LATCH: begin
            if (rom_dur == END_MARKER) begin
              song_done_q <= 1'b1;
              state       <= DONE;
            end else begin
              note_q     <= rom_note;
              dur_q      <= rom_dur;
              new_note_q <= 1'b1;
              state      <= WAIT;
            end
          end
          WAIT: begin
            if (bus.note_done) state <= ADVANCE;
          end
          ADVANCE: begin
            if (index == '1) begin
              song_done_q <= 1'b1;
              state       <= DONE;
            end else begin
              index <= index + ADDR_BITS'(1);
              state <= bus.play ? FETCH : IDLE;
            end
          end
          DONE: begin
            index <= '0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.new_note  = new_note_q;
  assign bus.note      = note_q;
  assign bus.duration  = dur_q;
  assign bus.song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader
// Directed bench for song_reader. Inputs change 1 ns after a rising edge
// and outputs are sampled there too. "lat" counts cycles from the edge that
// sampled the triggering input to the cycle the awaited output is seen.
module tb_song_reader;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  song_reader_if bus ();

  song_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_note_done();
    bus.note_done = 1'b1;
    tick();
    bus.note_done = 1'b0;
  endtask

  task automatic pulse_reset_play();
    bus.reset_play = 1'b1;
    tick();
    bus.reset_play = 1'b0;
  endtask

  // Bounded wait for new_note; lat is 12 if it never arrived.
  task automatic wait_strobe(output int lat);
    lat = 1;
    while (bus.new_note !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.play       = 1'b0;
    bus.reset_play = 1'b0;
    bus.song       = '0;
    bus.note_done  = 1'b0;
    tick();
    tick();
    checks++; if (bus.new_note !== 1'b0) begin errors++; $display("[TB] FAIL reset_new_note got=%b want=0", bus.new_note); end
    checks++; if (bus.note !== 6'd0) begin errors++; $display("[TB] FAIL reset_note got=%0d want=0", bus.note); end
    checks++; if (bus.duration !== 6'd0) begin errors++; $display("[TB] FAIL reset_duration got=%0d want=0", bus.duration); end
    checks++; if (bus.song_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_song_done got=%b want=0", bus.song_done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_first_note();
    int lat;
    int strobes;
    bus.song = 2'd2;
    bus.play = 1'b1;
    tick();
    wait_strobe(lat);
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL first_latency got=%0d want=3", lat); end
    checks++; if (bus.note !== 6'd17) begin errors++; $display("[TB] FAIL first_note got=%0d want=17", bus.note); end
    checks++; if (bus.duration !== 6'd8) begin errors++; $display("[TB] FAIL first_duration got=%0d want=8", bus.duration); end
    strobes = 0;
    repeat (6) begin
      tick();
      if (bus.new_note === 1'b1) strobes++;
    end
    checks++; if (strobes != 0) begin errors++; $display("[TB] FAIL first_hold_strobes got=%0d want=0", strobes); end
    checks++; if (bus.note !== 6'd17) begin errors++; $display("[TB] FAIL first_note_held got=%0d want=17", bus.note); end
  endtask

  task automatic test_note_to_note();
    int lat;
    logic [5:0] exp_note [3] = '{6'd33, 6'd34, 6'd35};
    logic [5:0] exp_dur  [3] = '{6'd2, 6'd3, 6'd4};
    for (int i = 0; i < 3; i++) begin
      pulse_note_done();
      wait_strobe(lat);
      checks++; if (lat != 4) begin errors++; $display("[TB] FAIL n2n_latency[%0d] got=%0d want=4", i, lat); end
      checks++; if (bus.note !== exp_note[i]) begin errors++; $display("[TB] FAIL n2n_note[%0d] got=%0d want=%0d", i, bus.note, exp_note[i]); end
      checks++; if (bus.duration !== exp_dur[i]) begin errors++; $display("[TB] FAIL n2n_duration[%0d] got=%0d want=%0d", i, bus.duration, exp_dur[i]); end
    end
  endtask

  task automatic test_pause();
    int lat;
    int strobes;
    pulse_note_done();
    wait_strobe(lat);
    checks++; if (bus.note !== 6'd36) begin errors++; $display("[TB] FAIL pause_idx4_note got=%0d want=36", bus.note); end
    pulse_note_done();
    wait_strobe(lat);
    checks++; if (bus.note !== 6'd37) begin errors++; $display("[TB] FAIL pause_idx5_note got=%0d want=37", bus.note); end
    bus.play = 1'b0;
    pulse_note_done();
    strobes = 0;
    repeat (100) begin
      if (bus.new_note === 1'b1) strobes++;
      tick();
    end
    checks++; if (strobes != 0) begin errors++; $display("[TB] FAIL pause_strobes got=%0d want=0", strobes); end
    bus.play = 1'b1;
    tick();
    wait_strobe(lat);
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL resume_latency got=%0d want=3", lat); end
    checks++; if (bus.note !== 6'd38) begin errors++; $display("[TB] FAIL resume_note got=%0d want=38", bus.note); end
    checks++; if (bus.duration !== 6'd7) begin errors++; $display("[TB] FAIL resume_duration got=%0d want=7", bus.duration); end
  endtask

  task automatic test_end_marker();
    int lat;
    int dones;
    int strobes;
    bus.play = 1'b0;
    bus.song = 2'd1;
    pulse_reset_play();
    bus.play = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      wait_strobe(lat);
      checks++; if (lat != (i == 0 ? 3 : 4)) begin errors++; $display("[TB] FAIL marker_latency[%0d] got=%0d", i, lat); end
      checks++; if (bus.note !== 6'(i + 20) || bus.duration !== 6'd3) begin errors++; $display("[TB] FAIL marker_entry[%0d] got=%0d/%0d want=%0d/3", i, bus.note, bus.duration, i + 20); end
      pulse_note_done();
    end
    lat = 1;
    while (bus.song_done !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL marker_done_latency got=%0d want=4", lat); end
    bus.play = 1'b0;
    dones = 1;
    strobes = 0;
    repeat (10) begin
      tick();
      if (bus.song_done === 1'b1) dones++;
      if (bus.new_note === 1'b1) strobes++;
    end
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL marker_done_count got=%0d want=1", dones); end
    checks++; if (strobes != 0) begin errors++; $display("[TB] FAIL marker_extra_strobes got=%0d want=0", strobes); end
    bus.play = 1'b1;
    tick();
    wait_strobe(lat);
    checks++; if (bus.note !== 6'd20) begin errors++; $display("[TB] FAIL marker_restart_note got=%0d want=20", bus.note); end
  endtask

  task automatic test_full_song();
    int lat;
    bus.play = 1'b0;
    bus.song = 2'd0;
    pulse_reset_play();
    bus.play = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      wait_strobe(lat);
      checks++; if (bus.note !== 6'(i + 1) || bus.duration !== 6'(i + 1)) begin errors++; $display("[TB] FAIL full_entry[%0d] got=%0d/%0d want=%0d/%0d", i, bus.note, bus.duration, i + 1, i + 1); end
      pulse_note_done();
    end
    lat = 1;
    while (bus.song_done !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL full_done_latency got=%0d want=2", lat); end
    bus.play = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_play();
    int lat;
    int sd;
    bus.song = 2'd2;
    pulse_reset_play();
    bus.play = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      wait_strobe(lat);
      pulse_note_done();
    end
    wait_strobe(lat);
    checks++; if (bus.note !== 6'd44 || bus.duration !== 6'd13) begin errors++; $display("[TB] FAIL rp_idx12 got=%0d/%0d want=44/13", bus.note, bus.duration); end
    bus.note_done  = 1'b1;
    bus.reset_play = 1'b1;
    tick();
    bus.note_done  = 1'b0;
    bus.reset_play = 1'b0;
    checks++; if (bus.note !== 6'd0 || bus.duration !== 6'd0) begin errors++; $display("[TB] FAIL rp_cleared got=%0d/%0d want=0/0", bus.note, bus.duration); end
    checks++; if (bus.new_note !== 1'b0 || bus.song_done !== 1'b0) begin errors++; $display("[TB] FAIL rp_strobes got=%b/%b want=0/0", bus.new_note, bus.song_done); end
    sd = 0;
    lat = 1;
    while (bus.new_note !== 1'b1 && lat < 12) begin
      tick();
      lat++;
      if (bus.song_done === 1'b1) sd++;
    end
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL rp_restart_latency got=%0d want=4", lat); end
    checks++; if (bus.note !== 6'd17 || bus.duration !== 6'd8) begin errors++; $display("[TB] FAIL rp_restart_entry got=%0d/%0d want=17/8", bus.note, bus.duration); end
    checks++; if (sd != 0) begin errors++; $display("[TB] FAIL rp_song_done got=%0d want=0", sd); end
  endtask

  task automatic test_async_reset();
    int activity;
    pulse_note_done();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.note !== 6'd0 || bus.duration !== 6'd0) begin errors++; $display("[TB] FAIL async_reset_data got=%0d/%0d want=0/0", bus.note, bus.duration); end
    checks++; if (bus.new_note !== 1'b0 || bus.song_done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_strobes got=%b/%b want=0/0", bus.new_note, bus.song_done); end
    #2;
    reset = 1'b0;
    bus.play = 1'b0;
    tick();
    activity = 0;
    repeat (3) begin
      pulse_note_done();
      repeat (6) begin
        if (bus.new_note === 1'b1 || bus.song_done === 1'b1) activity++;
        tick();
      end
    end
    checks++; if (activity != 0) begin errors++; $display("[TB] FAIL idle_note_done_activity got=%0d want=0", activity); end
    checks++; if (bus.note !== 6'd0) begin errors++; $display("[TB] FAIL idle_note got=%0d want=0", bus.note); end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_note_to_note();
    test_pause();
    test_end_marker();
    test_full_song();
    test_reset_play();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
